// File: rtl/ps2_key_encoder_pkg.sv
// Shared constants for the PS/2 key encoder: scan codes, command codes, direction encoding
// and the scan-code-to-command map used by the decoder.
package ps2_key_encoder_pkg;

    // Frame bit positions, counted from the start bit (0)
    localparam logic [3:0] PS2_BIT_LAST_DATA = 4'd8;
    localparam logic [3:0] PS2_BIT_PARITY    = 4'd9;
    localparam logic [3:0] PS2_BIT_STOP      = 4'd10;

    // Scan set 2 prefixes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Player 1: W S A D
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;
    // Player 2: arrow keys, only valid after the E0 prefix
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    // Player 3: I K J L
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_L = 8'h4B;
    // Player 4: T G F H
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_H = 8'h33;
    // Reset game
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Command codes on KEY_PRESSED
    localparam logic [4:0] KEY_RESET_GAME    = 5'd16;
    localparam logic [4:0] DEFAULT_IDLE_CODE = 5'd31;

    // Direction encoding shared with the directions block
    typedef enum logic [1:0] {
        DirUp    = 2'd0,  // y-1
        DirDown  = 2'd1,  // y+1
        DirLeft  = 2'd2,  // x-1
        DirRight = 2'd3   // x+1
    } dir_e;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBreak,
        StExtBreak
    } dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] code;
    } key_map_t;

    // code = 4*player + dir
    function automatic logic [4:0] key_code(input logic [1:0] player, input dir_e dir);
        return {1'b0, player, dir};
    endfunction

    // Make codes that map without an E0 prefix
    function automatic key_map_t map_base(input logic [7:0] sc);
        key_map_t m;
        m.hit = 1'b1;
        case (sc)
            SC_W:     m.code = key_code(2'd0, DirUp);
            SC_S:     m.code = key_code(2'd0, DirDown);
            SC_A:     m.code = key_code(2'd0, DirLeft);
            SC_D:     m.code = key_code(2'd0, DirRight);
            SC_I:     m.code = key_code(2'd2, DirUp);
            SC_K:     m.code = key_code(2'd2, DirDown);
            SC_J:     m.code = key_code(2'd2, DirLeft);
            SC_L:     m.code = key_code(2'd2, DirRight);
            SC_T:     m.code = key_code(2'd3, DirUp);
            SC_G:     m.code = key_code(2'd3, DirDown);
            SC_F:     m.code = key_code(2'd3, DirLeft);
            SC_H:     m.code = key_code(2'd3, DirRight);
            SC_SPACE: m.code = KEY_RESET_GAME;
            default: begin
                m.hit  = 1'b0;
                m.code = 5'd0;
            end
        endcase
        return m;
    endfunction

    // Make codes that map only after an E0 prefix (the keypad forms are ignored)
    function automatic key_map_t map_ext(input logic [7:0] sc);
        key_map_t m;
        m.hit = 1'b1;
        case (sc)
            SC_ARROW_UP:    m.code = key_code(2'd1, DirUp);
            SC_ARROW_DOWN:  m.code = key_code(2'd1, DirDown);
            SC_ARROW_LEFT:  m.code = key_code(2'd1, DirLeft);
            SC_ARROW_RIGHT: m.code = key_code(2'd1, DirRight);
            default: begin
                m.hit  = 1'b0;
                m.code = 5'd0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_encoder_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame shift,
// odd-parity/stop check and inactivity timeout. Emits one byte strobe per good frame.
module ps2_frame_rx
    import ps2_key_encoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // [1:0] two-stage synchroniser, [2] previous synced level for edge detection
    logic [2:0] clk_sync_q;
    logic [1:0] dat_sync_q;

    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;

    logic clk_fall;
    logic dat_s;

    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];

    // Synchronise both pins; idle-high reset value avoids a false edge out of reset
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    // Frame bit sequencing, parity/stop check and timeout
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        if (clk_fall) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high start bit is line noise: drop it silently
                if (!dat_s) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q <= PS2_BIT_LAST_DATA) begin
                shift_d   = {dat_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == PS2_BIT_PARITY) begin
                parity_d  = dat_s;
                bit_cnt_d = PS2_BIT_STOP;
            end else begin
                bit_cnt_d = 4'd0;
                if (dat_s && (^{shift_q, parity_q})) begin
                    strobe_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d     = '0;
                bit_cnt_d = 4'd0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Frame state registers; strobe and error are registered one-cycle pulses
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

    // shift_q is untouched until the next frame's data bits, so it is stable with the strobe
    assign rx_byte     = shift_q;
    assign byte_strobe = strobe_q;
    assign frame_err   = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 key encoder: turns scan set 2 make codes into one-cycle KEY_PRESSED commands.
module ps2_key_encoder
    import ps2_key_encoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [4:0]  IDLE_CODE      = DEFAULT_IDLE_CODE
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [4:0] KEY_PRESSED,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_strobe;
    logic       rx_err;

    dec_state_e state_q, state_d;
    logic [4:0] key_q, key_d;
    logic       valid_q, valid_d;
    key_map_t   base_map;
    key_map_t   ext_map;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .frame_err   (rx_err)
    );

    assign base_map = map_base(rx_byte);
    assign ext_map  = map_ext(rx_byte);

    // Decoder next state and command; only a byte strobe advances the FSM
    always_comb begin
        state_d = state_q;
        key_d   = IDLE_CODE;
        valid_d = 1'b0;
        if (rx_err) begin
            // A corrupted byte may have been a prefix: resynchronise
            state_d = StIdle;
        end else if (byte_strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_byte == SC_EXT) begin
                        state_d = StExt;
                    end else if (rx_byte == SC_BREAK) begin
                        state_d = StBreak;
                    end else if (base_map.hit) begin
                        key_d   = base_map.code;
                        valid_d = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_byte == SC_BREAK) begin
                        state_d = StExtBreak;
                    end else begin
                        state_d = StIdle;
                        if (ext_map.hit) begin
                            key_d   = ext_map.code;
                            valid_d = 1'b1;
                        end
                    end
                end
                // Releases are swallowed
                StBreak, StExtBreak: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Decoder state and registered one-cycle command pulse
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            key_q   <= IDLE_CODE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign KEY_PRESSED = key_q;
    assign key_valid   = valid_q;
    assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder. PS/2 clock and timeout are scaled down so the whole
// run stays short: a PS/2 bit lasts 2*HALF system cycles, well inside TMO.
module tb_ps2_key_encoder;

    localparam int unsigned TMO  = 500;
    localparam int          HALF = 20;
    localparam int          GAP  = 10;
    localparam logic [4:0]  IDLE = 5'd31;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [4:0] KEY_PRESSED;
    logic       key_valid;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state
    logic [4:0] keys[$];
    int cyc      = 0;
    int err_cnt  = 0;
    int err_cyc  = 0;
    int bad_inv  = 0;

    ps2_key_encoder #(
        .TIMEOUT_CYCLES (TMO),
        .IDLE_CODE      (IDLE)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .KEY_PRESSED (KEY_PRESSED),
        .key_valid   (key_valid),
        .frame_err   (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Record every command pulse and frame error, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (key_valid === 1'b1) keys.push_back(KEY_PRESSED);
        if (key_valid !== (KEY_PRESSED != IDLE)) bad_inv <= bad_inv + 1;
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        tick(HALF);
        PS2_CLK = 1'b0;
        tick(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Send the first nbits of a frame: start, D0..D7, odd parity (optionally flipped), stop
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] frm;
        frm = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(frm[i]);
        PS2_DAT = 1'b1;
        tick(GAP);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic test_reset();
        tick(3);
        n_vec++;
        if (KEY_PRESSED !== IDLE) begin
            n_err++;
            $display("FAIL reset_key: got %0d, expected %0d", KEY_PRESSED, IDLE);
        end
        n_vec++;
        if (key_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b err=%b, expected 0 0", key_valid, frame_err);
        end
        reset = 1'b0;
        tick(20);
        n_vec++;
        if (KEY_PRESSED !== IDLE || key_valid !== 1'b0 || keys.size() != 0 || err_cnt != 0) begin
            n_err++;
            $display("FAIL post_reset_idle: got key=%0d valid=%b pulses=%0d errs=%0d, expected 31 0 0 0",
                     KEY_PRESSED, key_valid, keys.size(), err_cnt);
        end
    endtask

    task automatic test_single_key();
        int kb = keys.size();
        send_byte(8'h1D);
        n_vec++;
        if (keys.size() - kb != 1) begin
            n_err++;
            $display("FAIL w_pulse_cycles: got %0d, expected 1", keys.size() - kb);
        end
        n_vec++;
        if (keys.size() > kb && keys[kb] !== 5'd0) begin
            n_err++;
            $display("FAIL w_code: got %0d, expected 0", keys[kb]);
        end
    endtask

    task automatic test_extended();
        int kb = keys.size();
        send_byte(8'hE0);
        send_byte(8'h74);
        n_vec++;
        if (keys.size() - kb != 1 || (keys.size() > kb && keys[kb] !== 5'd7)) begin
            n_err++;
            $display("FAIL ext_right: got %0d pulses first=%0d, expected 1 pulse of 7",
                     keys.size() - kb, (keys.size() > kb) ? keys[kb] : IDLE);
        end
        kb = keys.size();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        n_vec++;
        if (keys.size() != kb) begin
            n_err++;
            $display("FAIL ext_release: got %0d pulses, expected 0", keys.size() - kb);
        end
        send_byte(8'h74);
        n_vec++;
        if (keys.size() != kb) begin
            n_err++;
            $display("FAIL keypad_74: got %0d pulses, expected 0", keys.size() - kb);
        end
        send_byte(8'hE0);
        send_byte(8'h1D);
        n_vec++;
        if (keys.size() != kb) begin
            n_err++;
            $display("FAIL ext_base_key: got %0d pulses, expected 0", keys.size() - kb);
        end
        send_byte(8'h29);
        n_vec++;
        if (keys.size() - kb != 1 || (keys.size() > kb && keys[kb] !== 5'd16)) begin
            n_err++;
            $display("FAIL space: got %0d pulses first=%0d, expected 1 pulse of 16",
                     keys.size() - kb, (keys.size() > kb) ? keys[kb] : IDLE);
        end
    endtask

    task automatic test_parity_error();
        int kb = keys.size();
        int eb = err_cnt;
        send_frame(8'h43, 1'b1, 11);
        n_vec++;
        if (err_cnt - eb != 1) begin
            n_err++;
            $display("FAIL parity_err: got %0d error pulses, expected 1", err_cnt - eb);
        end
        n_vec++;
        if (keys.size() != kb) begin
            n_err++;
            $display("FAIL parity_nokey: got %0d pulses, expected 0", keys.size() - kb);
        end
        send_byte(8'h43);
        n_vec++;
        if (keys.size() - kb != 1 || (keys.size() > kb && keys[kb] !== 5'd8)) begin
            n_err++;
            $display("FAIL i_after_err: got %0d pulses first=%0d, expected 1 pulse of 8",
                     keys.size() - kb, (keys.size() > kb) ? keys[kb] : IDLE);
        end
    endtask

    task automatic test_timeout();
        int kb = keys.size();
        int eb = err_cnt;
        int t_fall;
        logic [10:0] frm;
        frm = {1'b1, ~^8'h2C, 8'h2C, 1'b0};
        for (int i = 0; i < 5; i++) ps2_bit(frm[i]);
        PS2_DAT = 1'b1;
        // The last falling edge was HALF cycles ago
        t_fall = cyc - HALF;
        tick(TMO - HALF - 10);
        n_vec++;
        if (err_cnt != eb) begin
            n_err++;
            $display("FAIL timeout_early: got %0d error pulses, expected 0", err_cnt - eb);
        end
        tick(TMO + 100);
        n_vec++;
        if (err_cnt - eb != 1) begin
            n_err++;
            $display("FAIL timeout_err: got %0d error pulses, expected 1", err_cnt - eb);
        end
        n_vec++;
        if (err_cyc - t_fall < int'(TMO) - 2 || err_cyc - t_fall > int'(TMO) + 8) begin
            n_err++;
            $display("FAIL timeout_time: got %0d cycles after edge, expected about %0d",
                     err_cyc - t_fall, TMO);
        end
        send_byte(8'h2C);
        n_vec++;
        if (keys.size() - kb != 1 || (keys.size() > kb && keys[kb] !== 5'd12)) begin
            n_err++;
            $display("FAIL t_after_timeout: got %0d pulses first=%0d, expected 1 pulse of 12",
                     keys.size() - kb, (keys.size() > kb) ? keys[kb] : IDLE);
        end
    endtask

    task automatic test_release_typematic();
        int kb = keys.size();
        send_byte(8'hF0);
        send_byte(8'h1B);
        n_vec++;
        if (keys.size() != kb) begin
            n_err++;
            $display("FAIL release_s: got %0d pulses, expected 0", keys.size() - kb);
        end
        for (int i = 0; i < 3; i++) send_byte(8'h1B);
        n_vec++;
        if (keys.size() - kb != 3) begin
            n_err++;
            $display("FAIL repeat_count: got %0d pulses, expected 3", keys.size() - kb);
        end
        n_vec++;
        if (keys.size() - kb == 3 &&
            (keys[kb] !== 5'd1 || keys[kb+1] !== 5'd1 || keys[kb+2] !== 5'd1)) begin
            n_err++;
            $display("FAIL repeat_codes: got %0d %0d %0d, expected 1 1 1",
                     keys[kb], keys[kb+1], keys[kb+2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int kb = keys.size();
        int eb = err_cnt;
        send_frame(8'h23, 1'b0, 4);
        reset = 1'b1;
        tick(5);
        n_vec++;
        if (KEY_PRESSED !== IDLE || key_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got key=%0d valid=%b err=%b, expected 31 0 0",
                     KEY_PRESSED, key_valid, frame_err);
        end
        reset = 1'b0;
        tick(TMO + 100);
        n_vec++;
        if (keys.size() != kb || err_cnt != eb) begin
            n_err++;
            $display("FAIL midreset_quiet: got %0d pulses %0d errors, expected 0 0",
                     keys.size() - kb, err_cnt - eb);
        end
        send_byte(8'h23);
        n_vec++;
        if (keys.size() - kb != 1 || (keys.size() > kb && keys[kb] !== 5'd3)) begin
            n_err++;
            $display("FAIL d_after_reset: got %0d pulses first=%0d, expected 1 pulse of 3",
                     keys.size() - kb, (keys.size() > kb) ? keys[kb] : IDLE);
        end
    endtask

    task automatic test_valid_tracks_code();
        n_vec++;
        if (bad_inv != 0) begin
            n_err++;
            $display("FAIL valid_vs_code: got %0d cycles out of step, expected 0", bad_inv);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_extended();
        test_parity_error();
        test_timeout();
        test_release_typematic();
        test_reset_mid_frame();
        test_valid_tracks_code();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
